// File: rtl/sisc_sequencer.sv
// rtl/sisc_sequencer.sv - multi-cycle fetch/decode/execute/memory/writeback sequencer for SISC
//
// Purpose:
//   Explicit state machine that replaces the single-pass control decode of the
//   SISC processor. Drives register file, ALU, status register, writeback mux,
//   program counter and instruction register, and evaluates branch conditions
//   against the status flags.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_f     in   asynchronous active-high reset
//   opcode    in   ir[31:28]
//   mm        in   ir[27:24], ALU function or branch condition mask
//   stat      in   status flags {C,N,V,Z}
//   mem_rdy   in   memory access complete (FETCH and MEM only)
//   mem_req   out  memory access request
//   dm_we     out  data-memory write (STR in MEM)
//   ir_load   out  load instruction register
//   pc_write  out  update program counter
//   pc_sel    out  PC source: 00 +1, 01 absolute imm, 10 PC+imm
//   pc_rst    out  clear program counter
//   rf_we     out  register-file write enable
//   wb_sel    out  writeback source: 0 ALU, 1 memory
//   alu_op    out  0000 idle, 0001 reg-reg, 0010 reg-imm, 0100 address
//   stat_en   out  per-flag status write enable
//   halted    out  high in HALT
//   state     out  current state code
//
// Configuration macro: SISC_MEM_WAIT_EN
//   defined   - FETCH and MEM wait for mem_rdy
//   undefined - mem_rdy ignored; FETCH and MEM last exactly one cycle

module sisc_sequencer (
    input  logic       clk,
    input  logic       rst_f,
    input  logic [3:0] opcode,
    input  logic [3:0] mm,
    input  logic [3:0] stat,
    input  logic       mem_rdy,
    output logic       mem_req,
    output logic       dm_we,
    output logic       ir_load,
    output logic       pc_write,
    output logic [1:0] pc_sel,
    output logic       pc_rst,
    output logic       rf_we,
    output logic       wb_sel,
    output logic [3:0] alu_op,
    output logic [3:0] stat_en,
    output logic       halted,
    output logic [2:0] state
);

    localparam logic [2:0] S_START     = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_MEM       = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;
    localparam logic [2:0] S_HALT      = 3'd7;

    localparam logic [3:0] OP_ALU_REG = 4'h1;
    localparam logic [3:0] OP_ALU_IMM = 4'h2;
    localparam logic [3:0] OP_BRA     = 4'h4;
    localparam logic [3:0] OP_BRR     = 4'h5;
    localparam logic [3:0] OP_LOD     = 4'h8;
    localparam logic [3:0] OP_STR     = 4'h9;
    localparam logic [3:0] OP_HLT     = 4'hF;

    localparam logic [3:0] ALU_IDLE = 4'b0000;
    localparam logic [3:0] ALU_REG  = 4'b0001;
    localparam logic [3:0] ALU_IMM  = 4'b0010;
    localparam logic [3:0] ALU_ADDR = 4'b0100;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_ABS = 2'b01;
    localparam logic [1:0] PC_REL = 2'b10;

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic       mem_done;
    logic       branch_taken;

`ifdef SISC_MEM_WAIT_EN
    assign mem_done = mem_rdy;
`else
    // Memory is treated as single-cycle; the handshake input is kept only so
    // the port list matches the wait-state build.
    logic unused_mem_rdy;
    assign unused_mem_rdy = mem_rdy;
    assign mem_done       = 1'b1;
`endif

    // An empty mask means "always"; otherwise any selected flag set takes it.
    assign branch_taken = (mm == 4'b0000) || ((stat & mm) != 4'b0000);

    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state_q <= S_START;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        dm_we    = 1'b0;
        ir_load  = 1'b0;
        pc_write = 1'b0;
        pc_sel   = PC_INC;
        pc_rst   = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        alu_op   = ALU_IDLE;
        stat_en  = 4'b0000;
        halted   = 1'b0;

        case (state_q)
            S_START: begin
                pc_rst  = 1'b1;
                state_d = S_FETCH;
            end

            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_done) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                    pc_sel   = PC_INC;
                    state_d  = S_DECODE;
                end
            end

            S_DECODE: begin
                state_d = (opcode == OP_HLT) ? S_HALT : S_EXECUTE;
            end

            S_EXECUTE: begin
                case (opcode)
                    OP_ALU_REG: begin
                        alu_op  = ALU_REG;
                        stat_en = 4'b1111;
                        state_d = S_WRITEBACK;
                    end
                    OP_ALU_IMM: begin
                        alu_op  = ALU_IMM;
                        stat_en = 4'b1111;
                        state_d = S_WRITEBACK;
                    end
                    OP_LOD, OP_STR: begin
                        alu_op  = ALU_ADDR;
                        state_d = S_MEM;
                    end
                    OP_BRA, OP_BRR: begin
                        if (branch_taken) begin
                            pc_write = 1'b1;
                            pc_sel   = (opcode == OP_BRA) ? PC_ABS : PC_REL;
                        end
                        state_d = S_FETCH;
                    end
                    default: begin
                        state_d = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                // Address must stay on the ALU output for the whole access.
                mem_req = 1'b1;
                alu_op  = ALU_ADDR;
                dm_we   = (opcode == OP_STR);
                if (mem_done) begin
                    state_d = (opcode == OP_LOD) ? S_WRITEBACK : S_FETCH;
                end
            end

            S_WRITEBACK: begin
                rf_we  = 1'b1;
                wb_sel = (opcode == OP_LOD);
                if (opcode == OP_ALU_REG) begin
                    alu_op = ALU_REG;
                end else if (opcode == OP_ALU_IMM) begin
                    alu_op = ALU_IMM;
                end
                state_d = S_FETCH;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = S_START;
            end
        endcase

        // While reset is high the decode must look like START even before the
        // state register settles, so no write enable can leak in that cycle.
        if (rst_f) begin
            mem_req  = 1'b0;
            dm_we    = 1'b0;
            ir_load  = 1'b0;
            pc_write = 1'b0;
            pc_sel   = PC_INC;
            pc_rst   = 1'b1;
            rf_we    = 1'b0;
            wb_sel   = 1'b0;
            alu_op   = ALU_IDLE;
            stat_en  = 4'b0000;
            halted   = 1'b0;
        end
    end

endmodule

// File: tb/tb_sisc_sequencer.sv
// tb/tb_sisc_sequencer.sv - directed self-checking bench for sisc_sequencer

module tb_sisc_sequencer;

    logic       clk = 1'b0;
    logic       rst_f;
    logic [3:0] opcode;
    logic [3:0] mm;
    logic [3:0] stat;
    logic       mem_rdy;
    logic       mem_req;
    logic       dm_we;
    logic       ir_load;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       pc_rst;
    logic       rf_we;
    logic       wb_sel;
    logic [3:0] alu_op;
    logic [3:0] stat_en;
    logic       halted;
    logic [2:0] state;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [17:0] e_start;
    logic [17:0] e_fetch;
    logic [17:0] e_fstall;
    logic [17:0] e_zero;
    logic [17:0] e_halt;
    logic [17:0] e_addr;
    logic [17:0] e_mem_ld;
    logic [17:0] e_mem_st;

    always #5 clk = ~clk;

    sisc_sequencer dut (
        .clk      (clk),
        .rst_f    (rst_f),
        .opcode   (opcode),
        .mm       (mm),
        .stat     (stat),
        .mem_rdy  (mem_rdy),
        .mem_req  (mem_req),
        .dm_we    (dm_we),
        .ir_load  (ir_load),
        .pc_write (pc_write),
        .pc_sel   (pc_sel),
        .pc_rst   (pc_rst),
        .rf_we    (rf_we),
        .wb_sel   (wb_sel),
        .alu_op   (alu_op),
        .stat_en  (stat_en),
        .halted   (halted),
        .state    (state)
    );

    // Expected output bundle, same field order as the observed one in chk.
    function automatic logic [17:0] ob(input logic mreq, input logic we, input logic irl,
                                       input logic pcw, input logic [1:0] psel,
                                       input logic prst, input logic rfw, input logic wbs,
                                       input logic [3:0] aop, input logic [3:0] sen,
                                       input logic hlt);
        return {mreq, we, irl, pcw, psel, prst, rfw, wbs, aop, sen, hlt};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [2:0] es, input logic [17:0] eo);
        logic [17:0] got;
        got = {mem_req, dm_we, ir_load, pc_write, pc_sel, pc_rst, rf_we, wb_sel,
               alu_op, stat_en, halted};
        n_asserts++;
        assert ({state, got} === {es, eo})
        else begin
            n_fail++;
            $error("FAIL %s: observed state=%0d outs=%05h, expected state=%0d outs=%05h",
                   tag, state, got, es, eo);
        end
    endtask

    // Runs a three-cycle instruction (branch or NOP) starting in FETCH.
    task automatic run_short(input string tag, input logic [3:0] op, input logic [3:0] m,
                             input logic [3:0] s, input logic pcw, input logic [1:0] psel);
        opcode = op;
        mm     = m;
        stat   = s;
        chk({tag, "_fetch"}, 3'd1, e_fetch);
        step();
        chk({tag, "_decode"}, 3'd2, e_zero);
        step();
        chk({tag, "_exec"}, 3'd3, ob(0, 0, 0, pcw, psel, 0, 0, 0, 4'b0000, 4'b0000, 0));
        step();
        chk({tag, "_next_fetch"}, 3'd1, e_fetch);
    endtask

    initial begin
        e_start  = ob(0, 0, 0, 0, 2'b00, 1, 0, 0, 4'b0000, 4'b0000, 0);
        e_fetch  = ob(1, 0, 1, 1, 2'b00, 0, 0, 0, 4'b0000, 4'b0000, 0);
        e_fstall = ob(1, 0, 0, 0, 2'b00, 0, 0, 0, 4'b0000, 4'b0000, 0);
        e_zero   = ob(0, 0, 0, 0, 2'b00, 0, 0, 0, 4'b0000, 4'b0000, 0);
        e_halt   = ob(0, 0, 0, 0, 2'b00, 0, 0, 0, 4'b0000, 4'b0000, 1);
        e_addr   = ob(0, 0, 0, 0, 2'b00, 0, 0, 0, 4'b0100, 4'b0000, 0);
        e_mem_ld = ob(1, 0, 0, 0, 2'b00, 0, 0, 0, 4'b0100, 4'b0000, 0);
        e_mem_st = ob(1, 1, 0, 0, 2'b00, 0, 0, 0, 4'b0100, 4'b0000, 0);

        // Reset and start; ALU reg instruction already presented.
        rst_f   = 1'b1;
        opcode  = 4'h1;
        mm      = 4'h2;
        stat    = 4'h0;
        mem_rdy = 1'b1;
        step();
        step();
        chk("reset_held", 3'd0, e_start);
        rst_f = 1'b0;
        #1;
        chk("reset_released", 3'd0, e_start);
        step();

        // ALU reg: 1,2,3,5,1
        chk("alu_fetch", 3'd1, e_fetch);
        step();
        chk("alu_decode", 3'd2, e_zero);
        step();
        chk("alu_exec", 3'd3, ob(0, 0, 0, 0, 2'b00, 0, 0, 0, 4'b0001, 4'b1111, 0));
        step();
        chk("alu_wb", 3'd5, ob(0, 0, 0, 0, 2'b00, 0, 1, 0, 4'b0001, 4'b0000, 0));
        step();
        chk("alu_next_fetch", 3'd1, e_fetch);

        // ALU imm with a FETCH stall when waits are enabled.
        opcode  = 4'h2;
        mem_rdy = 1'b0;
        #1;
`ifdef SISC_MEM_WAIT_EN
        chk("fetch_stall", 3'd1, e_fstall);
        step();
        chk("fetch_stall_hold", 3'd1, e_fstall);
        mem_rdy = 1'b1;
        #1;
        chk("fetch_release", 3'd1, e_fetch);
`else
        chk("fetch_rdy_ignored", 3'd1, e_fetch);
`endif
        step();
        chk("imm_decode", 3'd2, e_zero);
        step();
        chk("imm_exec", 3'd3, ob(0, 0, 0, 0, 2'b00, 0, 0, 0, 4'b0010, 4'b1111, 0));
        step();
        chk("imm_wb", 3'd5, ob(0, 0, 0, 0, 2'b00, 0, 1, 0, 4'b0010, 4'b0000, 0));
        step();
        mem_rdy = 1'b1;
        #1;
        chk("imm_next_fetch", 3'd1, e_fetch);

        // LOD with mem_rdy low for three MEM cycles.
        opcode = 4'h8;
        mm     = 4'h0;
        step();
        chk("lod_decode", 3'd2, e_zero);
        mem_rdy = 1'b0;
        step();
        chk("lod_exec", 3'd3, e_addr);
        step();
        chk("lod_mem", 3'd4, e_mem_ld);
`ifdef SISC_MEM_WAIT_EN
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lod_mem_wait", 3'd4, e_mem_ld);
        end
        mem_rdy = 1'b1;
`endif
        step();
        chk("lod_wb", 3'd5, ob(0, 0, 0, 0, 2'b00, 0, 1, 1, 4'b0000, 4'b0000, 0));
        mem_rdy = 1'b1;
        step();

        // Branches and NOP.
        run_short("bra_taken_flag", 4'h4, 4'b0001, 4'b0001, 1'b1, 2'b01);
        run_short("bra_not_taken",  4'h4, 4'b0001, 4'b0000, 1'b0, 2'b00);
        run_short("bra_always",     4'h4, 4'b0000, 4'b0000, 1'b1, 2'b01);
        run_short("brr_taken",      4'h5, 4'b0110, 4'b0100, 1'b1, 2'b10);
        run_short("brr_not_taken",  4'h5, 4'b1000, 4'b0111, 1'b0, 2'b00);
        run_short("nop",            4'h0, 4'b1111, 4'b1111, 1'b0, 2'b00);
        run_short("undef_op",       4'h3, 4'b0000, 4'b0000, 1'b0, 2'b00);

        // STR, then reset in the middle of the MEM cycle.
        opcode = 4'h9;
        mm     = 4'h0;
        step();
        chk("str_decode", 3'd2, e_zero);
        step();
        chk("str_exec", 3'd3, e_addr);
        mem_rdy = 1'b0;
        step();
        chk("str_mem", 3'd4, e_mem_st);
`ifdef SISC_MEM_WAIT_EN
        step();
        chk("str_mem_wait", 3'd4, e_mem_st);
`endif
        #1;
        rst_f = 1'b1;
        #1;
        chk("str_reset_mid_mem", 3'd0, e_start);
        step();
        rst_f   = 1'b0;
        mem_rdy = 1'b1;
        #1;
        chk("str_reset_start", 3'd0, e_start);
        step();
        chk("restart_fetch", 3'd1, e_fetch);

        // HLT: absorbing until reset.
        opcode = 4'hF;
        step();
        chk("hlt_decode", 3'd2, e_zero);
        step();
        chk("hlt_enter", 3'd7, e_halt);
        for (int i = 0; i < 20; i++) begin
            mem_rdy = i[0];
            opcode  = i[3:0];
            step();
            chk("hlt_hold", 3'd7, e_halt);
        end
        rst_f = 1'b1;
        #1;
        chk("hlt_reset", 3'd0, e_start);
        step();
        rst_f   = 1'b0;
        mem_rdy = 1'b1;
        opcode  = 4'h0;
        step();
        chk("hlt_restart_fetch", 3'd1, e_fetch);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
